fifo_drain: RTL and testbench

Downstream consumer of the multi-way address/data FIFO. Each fetch pops up to NUM_WAY entries in one cycle, parks them in a local staging buffer, and replays them one entry per cycle on a valid/ready stream to the image-memory write port. It converts the FIFO's wide, bursty read side into a steady single-entry stream.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_drain_if.sv | 25 ++
 rtl/fifo_drain_stage.sv | 57 +++++
 rtl/fifo_drain.sv | 95 +++++++++
 tb/tb_fifo_drain.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the multi-way FIFO drain path.
package fifo_pkg;
  localparam int NUM_WAY = 3;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} drain_state_e;

  // Length of the ones-run starting at bit 0; legal is low if any set bit follows a gap.
  function automatic logic [7:0] prefix_len(input logic [31:0] succ, input int n,
                                            output logic legal);
    logic [7:0] len;
    logic       gap;
    len   = '0;
    gap   = 1'b0;
    legal = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        if (!succ[i])  gap   = 1'b1;
        else if (gap)  legal = 1'b0;
        else           len   = len + 8'd1;
      end
    end
    return len;
  endfunction
endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read side plus the single-entry output stream of fifo_drain.
interface fifo_drain_if #(
  parameter int NUM_WAY = fifo_pkg::NUM_WAY,
  parameter int ADDR_W  = fifo_pkg::ADDR_W,
  parameter int DATA_W  = fifo_pkg::DATA_W
);
  logic                             fifo_empty;
  logic [NUM_WAY-1:0]               fifo_ren;
  logic [NUM_WAY-1:0]               fifo_success;
  logic [NUM_WAY-1:0][ADDR_W-1:0]   fifo_addr;
  logic [NUM_WAY-1:0][DATA_W-1:0]   fifo_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [ADDR_W-1:0]                m_addr;
  logic [DATA_W-1:0]                m_data;

  modport master (
    input  fifo_empty, fifo_success, fifo_addr, fifo_data, m_ready,
    output fifo_ren, m_valid, m_addr, m_data
  );
  modport slave (
    output fifo_empty, fifo_success, fifo_addr, fifo_data, m_ready,
    input  fifo_ren, m_valid, m_addr, m_data
  );
endinterface

// File: rtl/fifo_drain_stage.sv
// NUM_WAY-slot staging register file: bulk load, one-per-cycle advance, flush.
module fifo_drain_stage #(
  parameter int NUM_WAY = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 6,
  parameter int CW      = $clog2(NUM_WAY + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           load,
  input  logic                           advance,
  input  logic [CW-1:0]                  load_cnt,
  input  logic [NUM_WAY-1:0][ADDR_W-1:0] load_addr,
  input  logic [NUM_WAY-1:0][DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0]              rd_addr,
  output logic [DATA_W-1:0]              rd_data,
  output logic [CW-1:0]                  cnt
);
  localparam int IW = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  logic [IW-1:0]                  rd_idx;
  logic [NUM_WAY-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_WAY-1:0][DATA_W-1:0] slot_data;

  for (genvar i = 0; i < NUM_WAY; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end else if (load && (CW'(i) < load_cnt)) begin
        slot_addr[i] <= load_addr[i];
        slot_data[i] <= load_data[i];
      end
    end
  end

  // rd_idx wraps to 0 on the last advance so it never points past the slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rd_idx <= '0;
    end else if (flush) begin
      cnt    <= '0;
      rd_idx <= '0;
    end else if (load) begin
      cnt    <= load_cnt;
      rd_idx <= '0;
    end else if (advance) begin
      cnt    <= cnt - 1'b1;
      rd_idx <= (cnt == CW'(1)) ? '0 : rd_idx + 1'b1;
    end
  end

  assign rd_addr = slot_addr[rd_idx];
  assign rd_data = slot_data[rd_idx];
endmodule

// File: rtl/fifo_drain.sv
// Multi-way FIFO drain: wide pops staged locally, replayed one entry per cycle.
// Optional FIFO_DRAIN_STATS_EN adds pop_total/drop_total saturating counters.
module fifo_drain #(
  parameter int NUM_WAY = fifo_pkg::NUM_WAY,
  parameter int ADDR_W  = fifo_pkg::ADDR_W,
  parameter int DATA_W  = fifo_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          flush,
  fifo_drain_if.master  io,
  output logic          busy,
  output logic          err
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]   pop_total,
  output logic [7:0]    drop_total
`endif
);
  import fifo_pkg::*;

  localparam int CW = $clog2(NUM_WAY + 1);
  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] DRAIN = ST_DRAIN;

  logic [0:0]    state;
  logic [CW-1:0] cnt, k;
  logic [7:0]    plen;
  logic          legal, hs, fetch, load;

  always_comb begin
    legal = 1'b1;
    plen  = prefix_len(32'(io.fifo_success), NUM_WAY, legal);
    k     = CW'(plen);
  end

  assign io.m_valid = (state == DRAIN);
  assign hs         = io.m_valid & io.m_ready;
  // Refill overlaps the final handshake so a steady FIFO streams with no bubble.
  assign fetch      = rst_n & enable & ~io.fifo_empty & ~flush &
                      ((state == IDLE) | ((cnt == CW'(1)) & hs));
  assign io.fifo_ren = {NUM_WAY{fetch}};
  assign load       = fetch & (k != '0);
  assign busy       = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   state <= IDLE;
    else if (flush)                               state <= IDLE;
    else if (load)                                state <= DRAIN;
    else if (state == DRAIN && hs && cnt == CW'(1)) state <= IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err <= 1'b0;
    else if (fetch && !legal) err <= 1'b1;
  end

  fifo_drain_stage #(.NUM_WAY(NUM_WAY), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CW(CW)) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .load     (load),
    .advance  (hs),
    .load_cnt (k),
    .load_addr(io.fifo_addr),
    .load_data(io.fifo_data),
    .rd_addr  (io.m_addr),
    .rd_data  (io.m_data),
    .cnt      (cnt)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [7:0] drop_inc;
  logic [8:0] drop_sum;

  // A flush discards whatever the sink did not take in that same cycle.
  always_comb begin
    drop_inc = '0;
    if (flush)               drop_inc = 8'(cnt) - 8'(hs);
    else if (fetch && !legal) drop_inc = 8'($countones(io.fifo_success)) - 8'(k);
  end
  assign drop_sum = {1'b0, drop_total} + {1'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_total  <= '0;
      drop_total <= '0;
    end else begin
      if (hs && pop_total != 16'hFFFF) pop_total <= pop_total + 16'd1;
      drop_total <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain: FIFO model drives pops, monitor checks the stream.
module tb_fifo_drain;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic busy, err;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] pop_total;
  logic [7:0]  drop_total;
`endif

  fifo_drain_if io();

  fifo_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .io        (io),
    .busy      (busy),
    .err       (err)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .pop_total (pop_total),
    .drop_total(drop_total)
`endif
  );

  always #5 clk = ~clk;

  entry_t fq[$];     // entries waiting in the upstream FIFO
  entry_t exp_q[$];  // entries staged and owed to the sink, in order
  bit     err_exp;
  int     pop_exp, drop_exp;
  int     tests, fails;
  int     seq_n;
  logic   last_vld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_fifo(input int n);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      seq_n++;
      e.addr = 6'(seq_n);
      e.data = 6'(seq_n * 5 + 1);
      fq.push_back(e);
    end
  endtask

  task automatic chk_stats();
`ifdef FIFO_DRAIN_STATS_EN
    chk("pop_total", 32'(pop_total), 32'(pop_exp));
    chk("drop_total", 32'(drop_total), 32'(drop_exp));
`endif
  endtask

  // One clock of stimulus; success pattern is pat_in when use_pat, else random.
  task automatic step(input bit en, input bit fl, input bit rdy, input bit use_pat,
                      input logic [2:0] pat_in);
    logic [2:0] pat;
    int     npop, r;
    bit     gap, legal;
    int     dropped;
    entry_t e;
    @(negedge clk);
    enable = en; flush = fl; io.m_ready = rdy;
    io.fifo_empty = (fq.size() == 0);
    io.fifo_success = '0; io.fifo_addr = '0; io.fifo_data = '0;
    #1;
    last_vld = io.m_valid;
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    chk("m_valid", 32'(io.m_valid), 32'(exp_q.size() != 0));
    chk("err", 32'(err), 32'(err_exp));
    chk("fifo_ren", 32'(io.fifo_ren),
        (en && fq.size() != 0 && !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy)))
          ? 32'h7 : 32'h0);
    chk_stats();
    if (io.fifo_ren != '0) begin
      if (use_pat) pat = pat_in;
      else begin
        r = $urandom_range(0, 9);
        if (r < 7)      pat = 3'b111;
        else if (r < 9) pat = 3'((1 << $urandom_range(0, 3)) - 1);
        else            pat = 3'($urandom);
      end
      npop = 0; gap = 0; legal = 1; dropped = 0;
      for (int i = 0; i < 3; i++) begin
        if (pat[i] && fq.size() != 0) begin
          e = fq.pop_front();
          npop++;
          io.fifo_addr[i] = e.addr;
          io.fifo_data[i] = e.data;
          io.fifo_success[i] = 1'b1;
          if (gap) begin legal = 0; dropped++; end
          else exp_q.push_back(e);
        end else gap = 1;
      end
      if (!legal) begin err_exp = 1; drop_exp += dropped; end
    end
    if (fl) begin
      @(posedge clk);
      drop_exp += exp_q.size();
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n && io.m_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL m_out: valid entry %0h/%0h with none expected", io.m_addr, io.m_data);
      end else begin
        chk("m_addr", 32'(io.m_addr), 32'(exp_q[0].addr));
        chk("m_data", 32'(io.m_data), 32'(exp_q[0].data));
        if (io.m_ready) begin
          void'(exp_q.pop_front());
          pop_exp++;
        end
      end
    end
  end

  task automatic reset_check(input string nm);
    chk({nm, "_ren"}, 32'(io.fifo_ren), 0);
    chk({nm, "_valid"}, 32'(io.m_valid), 0);
    chk({nm, "_addr"}, 32'(io.m_addr), 0);
    chk({nm, "_data"}, 32'(io.m_data), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  initial begin
    logic [7:0] vbits;
    io.fifo_empty = 1'b1; io.fifo_success = '0; io.fifo_addr = '0; io.fifo_data = '0;
    io.m_ready = 1'b0;
    tests = 0; fails = 0; seq_n = 0; err_exp = 0; pop_exp = 0; drop_exp = 0;

    // Reset state, with a fetch-eligible FIFO to show ren is held off.
    push_fifo(3);
    enable = 1'b1; io.fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_check("reset");
    chk_stats();
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Three entries, full pop, drained back to back.
    step(1, 0, 1, 1, 3'b111);
    repeat (4) step(0, 0, 1, 0, 3'b000);

    // Six entries: refill coincides with the last handshake, no bubble.
    push_fifo(6);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 1, 3'b111);
      vbits[i] = last_vld;
    end
    chk("no_bubble", 32'(vbits), 32'h7E);

    // Two-way pop with backpressure in the middle.
    push_fifo(3);
    step(1, 0, 1, 1, 3'b011);
    step(0, 0, 1, 0, 3'b000);
    step(0, 0, 0, 0, 3'b000);
    step(0, 0, 1, 0, 3'b000);
    step(0, 0, 1, 0, 3'b000);

    // Non-contiguous success: way 0 kept, way 2 dropped, err sticks.
    push_fifo(2);
    step(1, 0, 1, 1, 3'b101);
    repeat (3) step(0, 0, 1, 0, 3'b000);

    // Flush with two entries staged.
    push_fifo(3);
    step(1, 0, 1, 1, 3'b111);
    step(0, 0, 1, 0, 3'b000);
    step(1, 1, 0, 0, 3'b000);
    step(0, 0, 1, 0, 3'b000);

    // Reset mid-drain, then a fresh pop.
    step(1, 0, 0, 1, 3'b111);
    step(0, 0, 0, 0, 3'b000);
    @(negedge clk);
    enable = 1'b1; io.fifo_empty = (fq.size() == 0); rst_n = 1'b0;
    #1 reset_check("mid_reset");
    exp_q.delete(); err_exp = 0; pop_exp = 0; drop_exp = 0;
    chk_stats();
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    push_fifo(2);
    step(1, 0, 1, 1, 3'b111);
    repeat (4) step(0, 0, 1, 0, 3'b000);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      bit fl;
      if (fq.size() < 8 && $urandom_range(0, 3) != 0) push_fifo($urandom_range(1, 3));
      fl = ($urandom_range(0, 99) < 3);
      step($urandom_range(0, 9) < 8, fl, fl ? 1'b0 : ($urandom_range(0, 9) < 7), 0, 3'b000);
    end
    repeat (5) step(0, 0, 1, 0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
